mem_port_arbiter: RTL and testbench

- Shares one memory-side request/response port between the instruction-cache refill path (requester 0) and the data-cache refill/writeback path (requester 1).
- Sits between the two cache memory interfaces and a single bus-bridge master, so the I-side and D-side traffic can use one memory port.
- Non-pipelined: one outstanding transaction; round-robin grant, locked until that transaction's response returns.

---
 rtl/mem_port_arbiter_if.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the two cache-side request/response ports (m0 = I-side
//               refill, m1 = D-side refill/writeback) and the single shared
//               memory-side port (s_*) handled by mem_port_arbiter.
//   m0_/m1_ : valid, ready, wen, addr, wdata, wmask, rvalid, rdata
//   s_      : valid, ready, wen, addr, wdata, wmask, rvalid, rdata
// Modports    : slave  - arbiter view (consumes m* requests, drives s_* request)
//               master - environment view (cache requesters + bus bridge)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
);
    logic                  m0_valid;
    logic                  m0_ready;
    logic                  m0_wen;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [MASK_WIDTH-1:0] m0_wmask;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_valid;
    logic                  m1_ready;
    logic                  m1_wen;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [MASK_WIDTH-1:0] m1_wmask;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  s_valid;
    logic                  s_ready;
    logic                  s_wen;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [MASK_WIDTH-1:0] s_wmask;
    logic                  s_rvalid;
    logic [DATA_WIDTH-1:0] s_rdata;

    modport slave (
        input  m0_valid, m0_wen, m0_addr, m0_wdata, m0_wmask,
        output m0_ready, m0_rvalid, m0_rdata,
        input  m1_valid, m1_wen, m1_addr, m1_wdata, m1_wmask,
        output m1_ready, m1_rvalid, m1_rdata,
        output s_valid, s_wen, s_addr, s_wdata, s_wmask,
        input  s_ready, s_rvalid, s_rdata
    );

    modport master (
        output m0_valid, m0_wen, m0_addr, m0_wdata, m0_wmask,
        input  m0_ready, m0_rvalid, m0_rdata,
        output m1_valid, m1_wen, m1_addr, m1_wdata, m1_wmask,
        input  m1_ready, m1_rvalid, m1_rdata,
        input  s_valid, s_wen, s_addr, s_wdata, s_wmask,
        output s_ready, s_rvalid, s_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one non-pipelined memory port between the I-cache refill
//               path (requester 0) and the D-cache refill/writeback path
//               (requester 1). One transaction in flight; the grant is locked
//               from acceptance until the downstream response returns.
// Ports       : clk   - clock
//               rst   - synchronous reset, active-high
//               bus   - mem_port_arbiter_if.slave (m0_*, m1_*, s_* signals)
//               grant - index of the current owner, meaningful while busy
//               busy  - a transaction is being issued or awaited
// Build macro : MEM_ARB_DSIDE_PRIO_EN - when defined, the D-side always wins a
//               simultaneous request; otherwise the grant is round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus,
    output logic                   grant,
    output logic                   busy
);

    typedef enum logic [1:0] {
        c_ST_IDLE  = 2'd0,
        c_ST_ISSUE = 2'd1,
        c_ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_s_valid;
    logic                  r_s_wen;
    logic [ADDR_WIDTH-1:0] r_s_addr;
    logic [DATA_WIDTH-1:0] r_s_wdata;
    logic [MASK_WIDTH-1:0] r_s_wmask;
    logic                  r_m0_rvalid;
    logic                  r_m1_rvalid;
    logic [DATA_WIDTH-1:0] r_m0_rdata;
    logic [DATA_WIDTH-1:0] r_m1_rdata;

    logic                  w_accept;
    logic                  w_pick;

    // Winner among the pending requesters; only meaningful when w_accept.
    always_comb begin
        w_pick = bus.m1_valid;
        if (bus.m0_valid && bus.m1_valid) begin
`ifdef MEM_ARB_DSIDE_PRIO_EN
            w_pick = 1'b1;
`else
            w_pick = ~r_last_grant;
`endif
        end
    end

    // Acceptance is gated by rst so a request is never acknowledged in a
    // cycle whose state update is being discarded by reset.
    assign w_accept     = ~rst && (r_state == c_ST_IDLE) && (bus.m0_valid || bus.m1_valid);

    assign bus.m0_ready  = w_accept & ~w_pick;
    assign bus.m1_ready  = w_accept &  w_pick;
    assign bus.m0_rvalid = r_m0_rvalid;
    assign bus.m1_rvalid = r_m1_rvalid;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rdata  = r_m1_rdata;
    assign bus.s_valid   = r_s_valid;
    assign bus.s_wen     = r_s_wen;
    assign bus.s_addr    = r_s_addr;
    assign bus.s_wdata   = r_s_wdata;
    assign bus.s_wmask   = r_s_wmask;
    assign grant         = r_grant;
    assign busy          = (r_state != c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_s_valid    <= 1'b0;
            r_s_wen      <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_s_wmask    <= '0;
            r_m0_rvalid  <= 1'b0;
            r_m1_rvalid  <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_s_valid    <= 1'b1;
                        r_state      <= c_ST_ISSUE;
                        if (w_pick) begin
                            r_s_wen   <= bus.m1_wen;
                            r_s_addr  <= bus.m1_addr;
                            r_s_wdata <= bus.m1_wdata;
                            r_s_wmask <= bus.m1_wmask;
                        end else begin
                            r_s_wen   <= bus.m0_wen;
                            r_s_addr  <= bus.m0_addr;
                            r_s_wdata <= bus.m0_wdata;
                            r_s_wmask <= bus.m0_wmask;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (bus.s_ready) begin
                        r_s_valid <= 1'b0;
                        r_state   <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    // Writes complete through the same pulse; rdata still
                    // carries whatever the bridge drove.
                    if (bus.s_rvalid) begin
                        if (r_grant) begin
                            r_m1_rdata  <= bus.s_rdata;
                            r_m1_rvalid <= 1'b1;
                        end else begin
                            r_m0_rdata  <= bus.s_rdata;
                            r_m0_rvalid <= 1'b1;
                        end
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_s_valid <= 1'b0;
                end
            endcase
        end
    end

    // A completion outside WAIT has no owner and is dropped; record it.
    cover property (@(posedge clk) disable iff (rst)
        bus.s_rvalid && (r_state != c_ST_WAIT));

    assert property (@(posedge clk) disable iff (rst)
        !(bus.m0_ready && bus.m1_ready));

    assert property (@(posedge clk) disable iff (rst)
        !(r_m0_rvalid && r_m1_rvalid));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Hand-derived vector
//               table, directed multi-cycle sequences and a randomized phase,
//               all cross-checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_AW = 64;
    localparam int c_DW = 128;
    localparam int c_MW = 16;
    localparam logic [127:0] c_RD_A = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic clk;
    logic rst;
    logic grant;
    logic busy;

    mem_port_arbiter_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .MASK_WIDTH(c_MW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .MASK_WIDTH(c_MW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .grant (grant),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- transaction-level reference model ----------------
    int           mo_owner;      // -1 when the port is free
    bit           mo_taken;      // downstream has accepted the request
    int           mo_last;
    int           mo_grant;
    bit           mo_pulse [2];
    logic [127:0] mo_rdata [2];
    logic         mo_wen;
    logic [63:0]  mo_addr;
    logic [127:0] mo_wdata;
    logic [15:0]  mo_wmask;

    task automatic model_reset();
        mo_owner = -1; mo_taken = 0; mo_last = 1; mo_grant = 0;
        mo_pulse[0] = 0; mo_pulse[1] = 0;
        mo_rdata[0] = '0; mo_rdata[1] = '0;
        mo_wen = 0; mo_addr = '0; mo_wdata = '0; mo_wmask = '0;
    endtask

    function automatic int model_pick();
        if (rst || mo_owner >= 0) return -1;
        if (bus.m0_valid && bus.m1_valid) begin
`ifdef MEM_ARB_DSIDE_PRIO_EN
            return 1;
`else
            return 1 - mo_last;
`endif
        end
        if (bus.m0_valid) return 0;
        if (bus.m1_valid) return 1;
        return -1;
    endfunction

    task automatic model_check();
        int p;
        p = model_pick();
        chk("m0_ready",  bus.m0_ready,  (p == 0));
        chk("m1_ready",  bus.m1_ready,  (p == 1));
        chk("s_valid",   bus.s_valid,   (mo_owner >= 0 && !mo_taken));
        chk("busy",      busy,          (mo_owner >= 0));
        chk("grant",     grant,         (mo_grant == 1));
        chk("s_wen",     bus.s_wen,     mo_wen);
        chk("s_addr",    bus.s_addr,    mo_addr);
        chk("s_wdata",   bus.s_wdata,   mo_wdata);
        chk("s_wmask",   bus.s_wmask,   mo_wmask);
        chk("m0_rvalid", bus.m0_rvalid, mo_pulse[0]);
        chk("m1_rvalid", bus.m1_rvalid, mo_pulse[1]);
        chk("m0_rdata",  bus.m0_rdata,  mo_rdata[0]);
        chk("m1_rdata",  bus.m1_rdata,  mo_rdata[1]);
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        int p;
        if (rst) begin
            model_reset();
            return;
        end
        p = model_pick();
        mo_pulse[0] = 0; mo_pulse[1] = 0;
        if (p >= 0) begin
            mo_owner = p; mo_last = p; mo_grant = p; mo_taken = 0;
            mo_wen   = (p == 1) ? bus.m1_wen   : bus.m0_wen;
            mo_addr  = (p == 1) ? bus.m1_addr  : bus.m0_addr;
            mo_wdata = (p == 1) ? bus.m1_wdata : bus.m0_wdata;
            mo_wmask = (p == 1) ? bus.m1_wmask : bus.m0_wmask;
        end else if (mo_owner >= 0 && !mo_taken) begin
            if (bus.s_ready) mo_taken = 1;
        end else if (mo_owner >= 0 && bus.s_rvalid) begin
            mo_pulse[mo_owner] = 1;
            mo_rdata[mo_owner] = bus.s_rdata;
            mo_owner = -1;
        end
    endtask

    // Inputs are set just after a falling edge; check, step, next falling edge.
    task automatic tick();
        #1;
        model_check();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic r, input logic v0, input logic v1,
                          input logic srdy, input logic srv);
        rst = r; bus.m0_valid = v0; bus.m1_valid = v1;
        bus.s_ready = srdy; bus.s_rvalid = srv;
    endtask

    // ---------------- hand-derived vector table ----------------
    typedef struct packed {
        logic rst, v0, v1, srdy, srv;
        logic e_rdy0, e_rdy1, e_sv, e_rv0, e_rv1, e_busy, e_grant, e_rd0, e_rd1;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int   grants [4];
        int   ng;
        int   sv_cnt;
        int   rv_cnt;
        int   exp_rr [4];

        //              rst v0 v1 rdy rv | rdy0 rdy1 sv rv0 rv1 busy gnt rd0 rd1
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

`ifdef MEM_ARB_DSIDE_PRIO_EN
        exp_rr = '{1, 1, 1, 1};
`else
        exp_rr = '{0, 1, 0, 1};
`endif

        bus.m0_wen = 1'b0; bus.m0_addr = 64'h0000_0000_8000_0040;
        bus.m0_wdata = '0; bus.m0_wmask = '0;
        bus.m1_wen = 1'b1; bus.m1_addr = 64'h0000_0000_0000_1000;
        bus.m1_wdata = {16{8'hAA}}; bus.m1_wmask = 16'hFFFF;
        bus.s_rdata = c_RD_A;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        model_reset();

        // ---- table: I-side read, D-side write with m0 waiting, reset, spurious rvalid
        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].rst, vecs[i].v0, vecs[i].v1, vecs[i].srdy, vecs[i].srv);
            #1;
            chk($sformatf("vec%0d_m0_ready", i),  bus.m0_ready,  vecs[i].e_rdy0);
            chk($sformatf("vec%0d_m1_ready", i),  bus.m1_ready,  vecs[i].e_rdy1);
            chk($sformatf("vec%0d_s_valid", i),   bus.s_valid,   vecs[i].e_sv);
            chk($sformatf("vec%0d_m0_rvalid", i), bus.m0_rvalid, vecs[i].e_rv0);
            chk($sformatf("vec%0d_m1_rvalid", i), bus.m1_rvalid, vecs[i].e_rv1);
            chk($sformatf("vec%0d_busy", i),      busy,          vecs[i].e_busy);
            chk($sformatf("vec%0d_grant", i),     grant,         vecs[i].e_grant);
            if (vecs[i].e_rd0) chk($sformatf("vec%0d_m0_rdata", i), bus.m0_rdata, c_RD_A);
            if (vecs[i].e_rd1) chk($sformatf("vec%0d_m1_rdata", i), bus.m1_rdata, c_RD_A);
            tick();
        end

        // ---- both requesters held valid from reset: grant order
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            bus.s_rvalid = busy && !bus.s_valid;
            #1;
            if (bus.m0_ready) begin grants[ng] = 0; ng++; end
            else if (bus.m1_ready) begin grants[ng] = 1; ng++; end
            tick();
        end
        chk("rr_grant_count", ng, 4);
        for (int k = 0; k < 4; k++)
            if (k < ng) chk($sformatf("rr_grant%0d", k), grants[k], exp_rr[k]);
        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.s_rvalid = busy && !bus.s_valid;
            tick();
        end

        // ---- D-side write with 5 cycles of backpressure
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.m1_valid = 1'b0;
        sv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            bus.s_ready = (i == 5);
            #1;
            if (bus.s_valid) sv_cnt++;
            tick();
        end
        chk("wr_svalid_cycles", sv_cnt, 6);
        bus.s_ready = 1'b0; bus.s_rvalid = 1'b1;
        tick();
        bus.s_rvalid = 1'b0;
        #1;
        chk("wr_m1_rvalid_next", bus.m1_rvalid, 1'b1);
        tick();
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.m1_rvalid) rv_cnt++;
            tick();
        end
        chk("wr_m1_rvalid_extra", rv_cnt, 0);

        // ---- reset while waiting for the response
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        bus.m0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_s_valid", bus.s_valid, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("abort_no_m0_rvalid", bus.m0_rvalid, 1'b0);
        chk("abort_no_m1_rvalid", bus.m1_rvalid, 1'b0);
`ifdef MEM_ARB_DSIDE_PRIO_EN
        chk("abort_regrant", bus.m1_ready, 1'b1);
`else
        chk("abort_regrant", bus.m0_ready, 1'b1);
`endif
        tick();

        // ---- randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.m0_valid = $urandom_range(0, 1) == 1;
            bus.m1_valid = $urandom_range(0, 1) == 1;
            bus.m0_wen   = $urandom_range(0, 1) == 1;
            bus.m1_wen   = $urandom_range(0, 1) == 1;
            bus.m0_addr  = {$urandom, $urandom};
            bus.m1_addr  = {$urandom, $urandom};
            bus.m0_wdata = {$urandom, $urandom, $urandom, $urandom};
            bus.m1_wdata = {$urandom, $urandom, $urandom, $urandom};
            bus.m0_wmask = 16'($urandom);
            bus.m1_wmask = 16'($urandom);
            bus.s_ready  = $urandom_range(0, 1) == 1;
            bus.s_rvalid = $urandom_range(0, 2) == 0;
            bus.s_rdata  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
